// File: rtl/fsm_feeder.sv
// Byte-stream feeder: buffers a valid/ready message, then replays it gap-free to the flag checker.
// Define FSM_FEEDER_ATTEMPT_CNT_EN to add the saturating attempt_cnt output.
module fsm_feeder #(
    parameter int unsigned DEPTH     = 64,
    parameter logic [7:0]  IDLE_BYTE = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    input  logic        ack,
    output logic [7:0]  di,
    input  logic        solved,
    output logic        busy,
    output logic        done,
    output logic        pass
`ifdef FSM_FEEDER_ATTEMPT_CNT_EN
    ,
    output logic [15:0] attempt_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    localparam logic [2:0] ST_LOAD  = 3'd0;
    localparam logic [2:0] ST_PRIME = 3'd1;
    localparam logic [2:0] ST_PLAY  = 3'd2;
    localparam logic [2:0] ST_CHECK = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]    state_q,  state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] len_q,    len_d;
    logic [7:0]    di_q,     di_d;
    logic          done_q,   done_d;
    logic          pass_q,   pass_d;
    logic          wr_en;
    logic [7:0]    mem_q [DEPTH];

`ifdef FSM_FEEDER_ATTEMPT_CNT_EN
    logic [15:0]   attempt_q, attempt_d;
`endif

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        len_d    = len_q;
        di_d     = IDLE_BYTE;
        done_d   = done_q;
        pass_d   = pass_q;
        wr_en    = 1'b0;
`ifdef FSM_FEEDER_ATTEMPT_CNT_EN
        attempt_d = attempt_q;
`endif
        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    // A full buffer terminates the message even without in_last.
                    if (in_last || (wr_ptr_q == PW'(DEPTH - 1))) begin
                        len_d   = wr_ptr_q + PW'(1);
                        state_d = ST_PRIME;
                    end
                end
            end
            ST_PRIME: begin
                // di is registered, so byte 0 is loaded here to appear in the first PLAY cycle.
                di_d     = mem_q[0];
                rd_ptr_d = PW'(1);
                state_d  = ST_PLAY;
            end
            ST_PLAY: begin
                if (rd_ptr_q == len_q) begin
                    state_d = ST_CHECK;
                end else begin
                    di_d     = mem_q[rd_ptr_q[AW-1:0]];
                    rd_ptr_d = rd_ptr_q + PW'(1);
                end
            end
            ST_CHECK: begin
                done_d  = 1'b1;
                pass_d  = solved;
                state_d = ST_DONE;
`ifdef FSM_FEEDER_ATTEMPT_CNT_EN
                if (attempt_q != 16'hFFFF) begin
                    attempt_d = attempt_q + 16'd1;
                end
`endif
            end
            ST_DONE: begin
                if (ack) begin
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                    wr_ptr_d = '0;
                    len_d    = '0;
                    state_d  = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_LOAD;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            len_q    <= '0;
            di_q     <= IDLE_BYTE;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            len_q    <= len_d;
            di_q     <= di_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_data;
        end
    end

`ifdef FSM_FEEDER_ATTEMPT_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            attempt_q <= '0;
        end else begin
            attempt_q <= attempt_d;
        end
    end

    assign attempt_cnt = attempt_q;
`endif

    assign in_ready = (state_q == ST_LOAD);
    assign busy     = (state_q == ST_PRIME) || (state_q == ST_PLAY) || (state_q == ST_CHECK);
    assign di       = di_q;
    assign done     = done_q;
    assign pass     = pass_q;

endmodule

// File: tb/tb_fsm_feeder.sv
// Bench for fsm_feeder: drives messages into the feeder, models the flag checker,
// and scores the replayed burst and pass result against queued expectations.
module tb_fsm_feeder;

    localparam int unsigned FLAG_LEN = 59;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic        ack = 1'b0;
    logic [7:0]  di;
    logic        solved;
    logic        busy;
    logic        done;
    logic        pass;
`ifdef FSM_FEEDER_ATTEMPT_CNT_EN
    logic [15:0] attempt_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int attempts = 0;

    logic [7:0] exp_di_q [$];
    logic       exp_pass_q [$];

    fsm_feeder #(.DEPTH(64), .IDLE_BYTE(8'h00)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_last(in_last),
        .in_ready(in_ready),
        .ack(ack),
        .di(di),
        .solved(solved),
        .busy(busy),
        .done(done),
`ifdef FSM_FEEDER_ATTEMPT_CNT_EN
        .attempt_cnt(attempt_cnt),
`endif
        .pass(pass)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] flag_b(input int i);
        case (i)
            0: flag_b = 8'h6A;
            1: flag_b = 8'h75;
            2: flag_b = 8'h73;
            3: flag_b = 8'h74;
            default: flag_b = 8'h41 + 8'((i * 7) % 26);
        endcase
    endfunction

    // Checker model: any wrong byte drops the match counter back to 0 (or 1 on a fresh 8'h6A).
    int chk_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_cnt <= 0;
        end else if (chk_cnt != FLAG_LEN && di == flag_b(chk_cnt)) begin
            chk_cnt <= chk_cnt + 1;
        end else if (di == flag_b(0)) begin
            chk_cnt <= 1;
        end else begin
            chk_cnt <= 0;
        end
    end
    assign solved = (chk_cnt == FLAG_LEN);

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Sends n bytes; bad_idx>=0 corrupts that byte; rst_at>=0 asserts reset in that PLAY cycle.
    task automatic run_msg(input int n, input int bad_idx, input bit use_last,
                           input bit extra, input int rst_at);
        logic [7:0] m [$];
        logic       exp_pass;
        for (int i = 0; i < n; i++) begin
            if (i < int'(FLAG_LEN)) m.push_back(flag_b(i));
            else m.push_back(8'h30 + 8'(i));
        end
        if (bad_idx >= 0) m[bad_idx] = ~m[bad_idx];
        exp_pass = (n == int'(FLAG_LEN)) && (bad_idx < 0);
        foreach (m[i]) exp_di_q.push_back(m[i]);
        exp_pass_q.push_back(exp_pass);

        for (int i = 0; i < n; i++) begin
            check_val("load_ready", 16'(in_ready), 16'd1);
            in_valid = 1'b1;
            in_data  = m[i];
            in_last  = use_last && (i == n - 1);
            @(posedge clk); #1;
        end
        if (extra) begin
            in_valid = 1'b1; in_data = 8'hEE; in_last = 1'b1;
        end else begin
            in_valid = 1'b0; in_last = 1'b0;
        end
        check_val("prime_ready", 16'(in_ready), 16'd0);
        check_val("prime_busy", 16'(busy), 16'd1);
        check_val("prime_di", 16'(di), 16'h00);

        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            check_val("play_di", 16'(di), 16'(exp_di_q.pop_front()));
            check_val("play_busy", 16'(busy), 16'd1);
            if (k == rst_at) begin
                rst = 1'b1;
                #1;
                check_val("rst_di", 16'(di), 16'h00);
                check_val("rst_busy", 16'(busy), 16'd0);
                check_val("rst_done", 16'(done), 16'd0);
                check_val("rst_ready", 16'(in_ready), 16'd1);
                in_valid = 1'b0; in_last = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                exp_di_q.delete();
                exp_pass_q.delete();
                return;
            end
        end

        @(posedge clk); #1;
        attempts++;
        check_val("check_di", 16'(di), 16'h00);
        check_val("check_busy", 16'(busy), 16'd1);
        check_val("check_done", 16'(done), 16'd0);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        check_val("done", 16'(done), 16'd1);
        check_val("pass", 16'(pass), 16'(exp_pass_q.pop_front()));
        check_val("done_busy", 16'(busy), 16'd0);
        check_val("done_ready", 16'(in_ready), 16'd0);
        check_val("done_di", 16'(di), 16'h00);
        @(posedge clk); #1;
        check_val("done_hold", 16'(done), 16'd1);
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        check_val("ack_done", 16'(done), 16'd0);
        check_val("ack_pass", 16'(pass), 16'd0);
        check_val("ack_ready", 16'(in_ready), 16'd1);
    endtask

    initial begin
        #1;
        check_val("rst_di0", 16'(di), 16'h00);
        check_val("rst_ready0", 16'(in_ready), 16'd1);
        check_val("rst_busy0", 16'(busy), 16'd0);
        check_val("rst_done0", 16'(done), 16'd0);
        check_val("rst_pass0", 16'(pass), 16'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_msg(59, -1, 1'b1, 1'b0, -1);
        run_msg(59, 9, 1'b1, 1'b0, -1);
        run_msg(64, -1, 1'b0, 1'b1, -1);
        run_msg(1, -1, 1'b1, 1'b0, -1);

        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        check_val("ack_in_load", 16'(in_ready), 16'd1);

        run_msg(59, -1, 1'b1, 1'b0, 4);
`ifdef FSM_FEEDER_ATTEMPT_CNT_EN
        attempts = 0;
`endif
        run_msg(59, -1, 1'b1, 1'b0, -1);

`ifdef FSM_FEEDER_ATTEMPT_CNT_EN
        check_val("attempt_cnt", attempt_cnt, 16'(attempts));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
